// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: scan-code constants, sequencer states and key-event type shared by the keyboard controller.
package ps2_kbd_pkg;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_e;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } kbd_ev_t;
  function automatic logic is_overrun(input logic [7:0] b);
    return b == 8'h00 || b == 8'hFF;
  endfunction
  function automatic logic is_ctl(input logic [7:0] b);
    return b == SC_BAT || b == SC_ACK || b == SC_RESEND;
  endfunction
endpackage

// File: rtl/ps2_kbd_modtrack.sv
// ps2_kbd_modtrack: holds shift/ctrl/alt/caps-lock state, updated by each formed key event.
module ps2_kbd_modtrack
  import ps2_kbd_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    ev_stb_i,
  input  kbd_ev_t ev_i,
  output logic    mod_shift_o,
  output logic    mod_ctrl_o,
  output logic    mod_alt_o,
  output logic    caps_lock_o
);
  logic lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d, alt_q, alt_d, caps_q, caps_d;
  logic plain;
  // E0 12 / E0 59 are fake shifts sent around extended keys, so shift only tracks plain codes
  always_comb begin
    plain    = !ev_i.ext;
    lshift_d = (ev_stb_i && plain && ev_i.code == SC_LSHIFT) ? !ev_i.brk : lshift_q;
    rshift_d = (ev_stb_i && plain && ev_i.code == SC_RSHIFT) ? !ev_i.brk : rshift_q;
    ctrl_d   = (ev_stb_i && ev_i.code == SC_CTRL) ? !ev_i.brk : ctrl_q;
    alt_d    = (ev_stb_i && ev_i.code == SC_ALT) ? !ev_i.brk : alt_q;
    caps_d   = caps_q ^ (ev_stb_i && plain && ev_i.code == SC_CAPS && !ev_i.brk && !ev_i.rpt);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ctrl_q   <= 1'b0;
      alt_q    <= 1'b0;
      caps_q   <= 1'b0;
    end else begin
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      ctrl_q   <= ctrl_d;
      alt_q    <= alt_d;
      caps_q   <= caps_d;
    end
  assign mod_shift_o = lshift_q | rshift_q;
  assign mod_ctrl_o  = ctrl_q;
  assign mod_alt_o   = alt_q;
  assign caps_lock_o = caps_q;
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: drains the PS/2 receiver FIFO, folds E0/F0 prefixes into key events
// and presents them one at a time on a valid/ready interface.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter bit REPEAT_FILTER = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  output logic       kbd_nextdata_n,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_repeat,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       caps_lock,
  output logic       err
);
  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       ext_q, ext_d, brk_q, brk_d, err_q, err_d, nd_n_q, ev_stb;
  logic [8:0] last_q, last_d;
  kbd_ev_t    ev_q, ev_d, cand;
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    last_d  = last_q;
    ev_d    = ev_q;
    err_d   = err_q | kbd_overflow;
    ev_stb  = 1'b0;
    cand    = '{code: byte_q, ext: ext_q, brk: brk_q, rpt: !brk_q && ({ext_q, byte_q} == last_q)};
    unique case (state_q)
      IDLE: if (kbd_ready) begin
        byte_d  = kbd_data;
        state_d = POP;
      end
      POP: state_d = DECODE;
      DECODE: begin
        state_d = IDLE;
        if (byte_q == SC_EXT) ext_d = 1'b1;
        else if (byte_q == SC_BRK) brk_d = 1'b1;
        else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (is_overrun(byte_q)) err_d = 1'b1;
          else if (!is_ctl(byte_q)) begin
            ev_stb = 1'b1;
            ev_d   = cand;
            if (!cand.rpt || !REPEAT_FILTER) state_d = EMIT;
            // last_make is never 0 for a real key, so clearing it re-arms repeat detection
            if (!cand.brk && !cand.rpt) last_d = {cand.ext, cand.code};
            else if (cand.brk && {cand.ext, cand.code} == last_q) last_d = '0;
          end
        end
      end
      EMIT: if (ev_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      last_q  <= '0;
      ev_q    <= '0;
      err_q   <= 1'b0;
      nd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      last_q  <= last_d;
      ev_q    <= ev_d;
      err_q   <= err_d;
      nd_n_q  <= state_d != POP;
    end
  ps2_kbd_modtrack u_mod (
    .clk         (clk),
    .rst         (rst),
    .ev_stb_i    (ev_stb),
    .ev_i        (cand),
    .mod_shift_o (mod_shift),
    .mod_ctrl_o  (mod_ctrl),
    .mod_alt_o   (mod_alt),
    .caps_lock_o (caps_lock)
  );
  assign kbd_nextdata_n = nd_n_q;
  assign ev_valid       = state_q == EMIT;
  assign ev_code        = ev_q.code;
  assign ev_ext         = ev_q.ext;
  assign ev_break       = ev_q.brk;
  assign ev_repeat      = ev_q.rpt;
  assign err            = err_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: scoreboard bench with a receiver-FIFO model driving two controllers (repeat forward / filter).
module tb_ps2_kbd_ctrl;
  import ps2_kbd_pkg::*;
  logic       clk = 1'b0, rst = 1'b1, kbd_overflow = 1'b0, ev_ready = 1'b1;
  logic [7:0] kbd_data = '0, kbd_data2 = '0;
  logic       kbd_ready = 1'b0, kbd_ready2 = 1'b0, ev_ready2 = 1'b1;
  logic       kbd_nextdata_n, ev_valid, ev_ext, ev_break, ev_repeat;
  logic [7:0] ev_code, ev_code2;
  logic       mod_shift, mod_ctrl, mod_alt, caps_lock, err;
  logic       nd2, ev_valid2, ev_ext2, ev_break2, ev_repeat2, ms2, mc2, ma2, cl2, err2;
  logic [7:0] fifo[$], fifo2[$];
  kbd_ev_t    exp_q[$], exp2[$], mon_e, mon_e2;
  int         checks = 0, errors = 0, pops = 0, p0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.REPEAT_FILTER(1'b0)) dut (
    .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready), .kbd_overflow(kbd_overflow),
    .kbd_nextdata_n(kbd_nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .ev_repeat(ev_repeat), .mod_shift(mod_shift),
    .mod_ctrl(mod_ctrl), .mod_alt(mod_alt), .caps_lock(caps_lock), .err(err)
  );
  ps2_kbd_ctrl #(.REPEAT_FILTER(1'b1)) u_filt (
    .clk(clk), .rst(rst), .kbd_data(kbd_data2), .kbd_ready(kbd_ready2), .kbd_overflow(1'b0),
    .kbd_nextdata_n(nd2), .ev_valid(ev_valid2), .ev_ready(ev_ready2), .ev_code(ev_code2),
    .ev_ext(ev_ext2), .ev_break(ev_break2), .ev_repeat(ev_repeat2), .mod_shift(ms2),
    .mod_ctrl(mc2), .mod_alt(ma2), .caps_lock(cl2), .err(err2)
  );

  // receiver FIFO model: pop on the strobe, head/ready visible one cycle later
  always @(posedge clk) begin
    if (!kbd_nextdata_n) begin
      pops++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    if (!nd2 && fifo2.size() != 0) void'(fifo2.pop_front());
  end
  always @(negedge clk) begin
    kbd_ready  = fifo.size() != 0;
    kbd_data   = kbd_ready ? fifo[0] : 8'h00;
    kbd_ready2 = fifo2.size() != 0;
    kbd_data2  = kbd_ready2 ? fifo2[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ev_unexpected: got %h/%b%b%b expected none", ev_code, ev_ext, ev_break, ev_repeat);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ev_code, ev_ext, ev_break, ev_repeat} !== mon_e) begin
          errors++;
          $display("FAIL ev: got %h/%b%b%b expected %h/%b%b%b", ev_code, ev_ext, ev_break, ev_repeat,
                   mon_e.code, mon_e.ext, mon_e.brk, mon_e.rpt);
        end
      end
    end
    if (!rst && ev_valid2 && ev_ready2) begin
      checks++;
      if (exp2.size() == 0) begin
        errors++;
        $display("FAIL ev_filt_unexpected: got %h/%b%b%b expected none", ev_code2, ev_ext2, ev_break2, ev_repeat2);
      end else begin
        mon_e2 = exp2.pop_front();
        if ({ev_code2, ev_ext2, ev_break2, ev_repeat2} !== mon_e2) begin
          errors++;
          $display("FAIL ev_filt: got %h/%b%b%b expected %h/%b%b%b", ev_code2, ev_ext2, ev_break2, ev_repeat2,
                   mon_e2.code, mon_e2.ext, mon_e2.brk, mon_e2.rpt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  task automatic ev(input logic [7:0] c, input logic x, input logic b, input logic r);
    exp_q.push_back('{code: c, ext: x, brk: b, rpt: r});
  endtask
  task automatic put(input logic [7:0] b);
    fifo.push_back(b);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || ev_valid || fifo2.size() != 0 || exp2.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    if (n >= 400) chk("wait_idle_timeout", 32'(n), 32'd0);
  endtask
  task automatic pulse_rst();
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {kbd_nextdata_n, ev_valid, mod_shift, mod_ctrl, mod_alt, caps_lock, err}, 7'b1000000);
    chk("rst_code", {ev_code, ev_ext, ev_break, ev_repeat}, 0);
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outputs_init", {kbd_nextdata_n, ev_valid, mod_shift, mod_ctrl, mod_alt, caps_lock, err}, 7'b1000000);
    @(posedge clk); #2 rst = 1'b0;
    // single key, plus the filtering instance in parallel
    ev(8'h1C, 0, 0, 0); ev(8'h1C, 0, 1, 0);
    exp2.push_back('{code: 8'h1C, ext: 1'b0, brk: 1'b0, rpt: 1'b0});
    exp2.push_back('{code: 8'h1C, ext: 1'b0, brk: 1'b1, rpt: 1'b0});
    foreach (fifo2[i]) fifo2[i] = fifo2[i];
    fifo2.push_back(8'h1C); fifo2.push_back(8'h1C); fifo2.push_back(8'h1C);
    fifo2.push_back(8'hF0); fifo2.push_back(8'h1C);
    p0 = pops;
    put(8'h1C); put(8'hF0); put(8'h1C);
    wait_idle();
    chk("single_pops", 32'(pops - p0), 32'd3);
    // extended key
    p0 = pops;
    ev(8'h75, 1, 0, 0); ev(8'h75, 1, 1, 0);
    put(8'hE0); put(8'h75); put(8'hE0); put(8'hF0); put(8'h75);
    wait_idle();
    chk("ext_pops", 32'(pops - p0), 32'd5);
    // auto-repeat held off by backpressure
    @(posedge clk); #2 ev_ready = 1'b0;
    p0 = pops;
    ev(8'h1C, 0, 0, 0); ev(8'h1C, 0, 0, 1); ev(8'h1C, 0, 0, 1);
    put(8'h1C); put(8'h1C); put(8'h1C);
    repeat (20) @(negedge clk);
    chk("stall_pops", 32'(pops - p0), 32'd1);
    chk("stall_valid", {ev_valid, kbd_ready}, 2'b11);
    chk("stall_event", {ev_code, ev_ext, ev_break, ev_repeat}, {8'h1C, 3'b000});
    @(posedge clk); #2 ev_ready = 1'b1;
    wait_idle();
    chk("repeat_pops", 32'(pops - p0), 32'd3);
    ev(8'h1C, 0, 1, 0);
    put(8'hF0); put(8'h1C);
    wait_idle();
    // modifiers and caps lock
    ev(8'h12, 0, 0, 0); put(8'h12); wait_idle();
    chk("shift_make", {mod_shift, caps_lock}, 2'b10);
    ev(8'h58, 0, 0, 0); put(8'h58); wait_idle();
    chk("caps_on", {mod_shift, caps_lock}, 2'b11);
    ev(8'h58, 0, 1, 0); ev(8'h58, 0, 0, 0); put(8'hF0); put(8'h58); put(8'h58); wait_idle();
    chk("caps_off", {mod_shift, caps_lock}, 2'b10);
    ev(8'h12, 0, 1, 0); put(8'hF0); put(8'h12); wait_idle();
    chk("shift_break", {mod_shift, caps_lock}, 2'b00);
    ev(8'h14, 0, 0, 0); ev(8'h11, 1, 0, 0); put(8'h14); put(8'hE0); put(8'h11); wait_idle();
    chk("ctrl_alt_make", {mod_ctrl, mod_alt}, 2'b11);
    ev(8'h14, 1, 1, 0); ev(8'h11, 0, 1, 0);
    put(8'hE0); put(8'hF0); put(8'h14); put(8'hF0); put(8'h11); wait_idle();
    chk("ctrl_alt_break", {mod_ctrl, mod_alt}, 2'b00);
    chk("err_clear", err, 1'b0);
    // control and overrun bytes
    ev(8'h1C, 0, 0, 0);
    put(8'hAA); put(8'hFA); put(8'h00); put(8'h1C);
    wait_idle();
    chk("err_overrun", err, 1'b1);
    pulse_rst();
    chk("err_after_rst", err, 1'b0);
    @(posedge clk); #2 kbd_overflow = 1'b1;
    @(posedge clk); #2 kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_overflow", err, 1'b1);
    // reset mid-sequence drops the pending E0
    ev(8'h12, 0, 0, 0); put(8'h12); put(8'hE0);
    wait_idle();
    chk("shift_before_rst", mod_shift, 1'b1);
    pulse_rst();
    ev(8'h75, 0, 0, 0); put(8'h75);
    wait_idle();
    chk("mod_after_rst", {mod_shift, err}, 2'b00);
    chk("exp_drained", 32'(exp_q.size() + exp2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Sequencer sitting between the ps2_keyboard receiver FIFO and system consumers (VGA terminal, NVBoard display, CPU MMIO).
- Drains received bytes through the receiver's ready/nextdata_n handshake.
- Folds the E0 (extended) and F0 (break) prefixes into single key events.
- Tracks modifier and caps-lock state.
- Presents one event at a time on a valid/ready interface.

Parameters:
REPEAT_FILTER, 0, 1 = silently drop auto-repeat makes; 0 = forward them with ev_repeat=1

Ports:
clk  in  1  system clock, shared with the receiver
rst  in  1  asynchronous active-high reset
kbd_data  in  8  receiver FIFO head byte
kbd_ready  in  1  receiver FIFO non-empty
kbd_overflow  in  1  receiver sticky overflow
kbd_nextdata_n  out  1  active-low pop strobe to receiver
ev_valid  out  1  key event available
ev_ready  in  1  consumer accepts event
ev_code  out  8  scan code, prefixes stripped
ev_ext  out  1  event was E0-prefixed
ev_break  out  1  1 = release, 0 = press
ev_repeat  out  1  press of the code currently held (auto-repeat)
mod_shift  out  1  left (12) or right (59) shift held
mod_ctrl  out  1  ctrl (14, either E0 or plain) held
mod_alt  out  1  alt (11, either E0 or plain) held
caps_lock  out  1  caps-lock toggle state
err  out  1  sticky: kbd_overflow seen, or 00/FF overrun byte received

Behaviour:
- Reset (async, rst=1):
  - All state regs to 0; FSM to IDLE.
  - kbd_nextdata_n=1; ev_valid=0; all mod/caps/err=0; last_make=0; prefix flags cleared.
  - Reset mid-sequence discards any latched byte and pending prefixes.
  - The receiver is not reset by this block.
- FSM states: IDLE, POP, DECODE, EMIT.
  - IDLE: if kbd_ready=1, latch kbd_data into byte_r and go to POP; else stay.
  - POP: kbd_nextdata_n=0 for exactly this one cycle (registered output, glitch-free); go to DECODE. kbd_nextdata_n=1 in every other state.
  - DECODE: classify byte_r (below); go to EMIT if an event is formed, else IDLE.
  - EMIT: ev_valid=1, all ev_* stable; on ev_valid & ev_ready go to IDLE. No new pop while in EMIT; backpressure is absorbed by the receiver FIFO.
- Latency and throughput:
  - Byte seen with kbd_ready at IDLE cycle T gives ev_valid from T+3.
  - Minimum 4 cycles per event byte (3 per prefix byte).
  - Never more than one pop per byte. kbd_ready is only sampled in IDLE, so the 1-cycle receiver update lag is safe.
- Classification in DECODE:
  - E0: set ext_pend.
  - F0: set brk_pend. ext_pend is kept, so E0 F0 xx is an extended break.
  - 00 or FF: set err; clear both prefixes; no event.
  - AA, FA, FE (BAT/ack/resend): clear prefixes; no event.
  - Any other byte forms an event: ev_code=byte_r, ev_ext=ext_pend, ev_break=brk_pend; then clear both prefixes.
- Repeat detection:
  - Make with {ext,code} == last_make: ev_repeat=1. If REPEAT_FILTER=1, no event is emitted and the FSM goes to IDLE.
  - Other make: last_make <= {ext,code}.
  - Break matching last_make clears last_make to 0. Code 00 is never a valid key.
- Modifier update: applied in DECODE for every formed event, including filtered repeats.
  - shift, ctrl and alt are set on make and cleared on break of their codes.
  - Shift uses separate left/right held bits; mod_shift = OR of the two.
  - caps_lock toggles only on a non-repeat make of 58 (non-ext).
- Modifier events are still emitted as normal events.
- err sets when kbd_overflow=1 in any cycle; it clears only on rst.
- Simultaneous kbd_ready and ev_valid: the event is held and no pop occurs.

Decomposition:
- Package ps2_kbd_pkg holds:
  - byte constants: SC_EXT=E0, SC_BRK=F0, SC_BAT=AA, SC_ACK=FA, SC_RESEND=FE, SC_LSHIFT=12, SC_RSHIFT=59, SC_CTRL=14, SC_ALT=11, SC_CAPS=58;
  - the FSM state enum;
  - the event struct {code, ext, brk, repeat}.
- Natural sub-module: ps2_kbd_modtrack. It takes a formed-event strobe plus the event fields and owns the shift/ctrl/alt/caps registers.

Test Plan:
- Single key: FIFO bytes 1C, F0, 1C with ev_ready=1 -> two events: {1C, ext0, brk0, rep0}, then {1C, ext0, brk1}. Exactly 3 one-cycle pulses on kbd_nextdata_n.
- Extended key: E0 75 E0 F0 75 -> {75, ext1, brk0}, then {75, ext1, brk1}. No event emitted for the prefix bytes.
- Repeat and backpressure: 1C 1C 1C with ev_ready=0 for 20 cycles, REPEAT_FILTER=0. First event is held stable with no pops during the stall. After release, events arrive with rep=0,1,1. With REPEAT_FILTER=1, only one event is emitted.
- Modifiers: 12, 58, F0 58, 58, F0 12 -> mod_shift 1 then 0; caps_lock 1 after the first 58 and 0 after the second.
- Error/control bytes: AA, FA, 00, then 1C -> only the 1C event is emitted; err=1 stays set. A kbd_overflow pulse alone also sets err.
- Reset mid-sequence: E0 consumed, rst asserted for 1 cycle, then 75 arrives -> event {75, ext0}; all outputs 0 during rst.
